// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants, FSM encoding and flag indices for keyboard_decoder
package kbd_pkg;

  localparam logic [7:0] KB_PFX_EXT   = 8'hE0;
  localparam logic [7:0] KB_PFX_BRK   = 8'hF0;
  localparam logic [7:0] KB_SC_LSHIFT = 8'h12;
  localparam logic [7:0] KB_SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2
  } kbd_state_e;

  localparam int FLG_BRK   = 2;
  localparam int FLG_EXT   = 1;
  localparam int FLG_SHIFT = 0;

endpackage

// File: rtl/keyboard_decoder_if.sv
// rtl/keyboard_decoder_if.sv - receiver handshake and CPU event-port bundle for keyboard_decoder
interface keyboard_decoder_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          kb_ready;
  logic [7:0]    kb_code;
  logic          kb_rdn;
  logic          cpu_rd;
  logic          evt_valid;
  logic [2:0]    evt_flags;
  logic [7:0]    evt_code;
  logic [7:0]    evt_ascii;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output kb_ready, kb_code, cpu_rd,
    input  kb_rdn, evt_valid, evt_flags, evt_code, evt_ascii, fifo_count, overflow
  );

  modport slave (
    input  kb_ready, kb_code, cpu_rd,
    output kb_rdn, evt_valid, evt_flags, evt_code, evt_ascii, fifo_count, overflow
  );
endinterface

// File: rtl/kbd_ascii_map.sv
// rtl/kbd_ascii_map.sv - combinational set-2 scancode to ASCII lookup (letters, digits, space, enter)
module kbd_ascii_map
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base;

  always_comb begin
    base = 8'h00;
    case (code)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;  8'h23: base = 8'h64;
      8'h24: base = 8'h65;  8'h2B: base = 8'h66;  8'h34: base = 8'h67;  8'h33: base = 8'h68;
      8'h43: base = 8'h69;  8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;  8'h4D: base = 8'h70;
      8'h15: base = 8'h71;  8'h2D: base = 8'h72;  8'h1B: base = 8'h73;  8'h2C: base = 8'h74;
      8'h3C: base = 8'h75;  8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;  8'h26: base = 8'h33;
      8'h25: base = 8'h34;  8'h2E: base = 8'h35;  8'h36: base = 8'h36;  8'h3D: base = 8'h37;
      8'h3E: base = 8'h38;  8'h46: base = 8'h39;
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      default: base = 8'h00;
    endcase
  end

  // Shift only changes case of letters; digits, space and enter are unaffected.
  assign ascii = (shift && base >= 8'h61 && base <= 8'h7A) ? (base - 8'h20) : base;

endmodule

// File: rtl/keyboard_decoder.sv
// rtl/keyboard_decoder.sv - PS/2 scancode decoder with event FIFO; define KBD_ASCII_EN for ASCII lookup
module keyboard_decoder
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic               fclk,
  input  logic               rst,
  keyboard_decoder_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  kbd_state_e state, state_nxt;
  logic       latch_en, capture, rdn;

  logic [7:0] byte_q;
  logic       ext_pend, brk_pend, shift_q;
  logic       is_ext, is_brk, is_shift, push;
  logic [2:0] flags_in;

  logic [2:0]    flag_mem [DEPTH];
  logic [7:0]    code_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_q, full, empty, pop, wr_en;

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.kb_ready) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_ACK;
      ST_ACK:     if (!bus.kb_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_en = 1'b0;
    capture  = 1'b0;
    rdn      = 1'b0;
    case (state)
      ST_IDLE:    latch_en = bus.kb_ready;
      ST_CAPTURE: capture  = 1'b1;
      ST_ACK:     rdn      = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst)          byte_q <= 8'h00;
    else if (latch_en) byte_q <= bus.kb_code;
  end

  assign is_ext   = (byte_q == KB_PFX_EXT);
  assign is_brk   = (byte_q == KB_PFX_BRK);
  assign is_shift = (byte_q == KB_SC_LSHIFT) || (byte_q == KB_SC_RSHIFT);
  assign push     = capture && !is_ext && !is_brk;

  always_comb begin
    flags_in            = 3'b000;
    flags_in[FLG_BRK]   = brk_pend;
    flags_in[FLG_EXT]   = ext_pend;
    flags_in[FLG_SHIFT] = shift_q;
  end

  // Pushed shift bit is the pre-update value; extended shift codes never touch shift state.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      shift_q  <= 1'b0;
    end else if (capture) begin
      if (is_ext) begin
        ext_pend <= 1'b1;
      end else if (is_brk) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        if (!ext_pend && is_shift) shift_q <= !brk_pend;
      end
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = bus.cpu_rd && !empty;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge fclk) begin
    if (wr_en) begin
      flag_mem[wr_ptr] <= flags_in;
      code_mem[wr_ptr] <= byte_q;
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign bus.kb_rdn     = rdn;
  assign bus.evt_valid  = !empty;
  assign bus.evt_flags  = empty ? 3'b000 : flag_mem[rd_ptr];
  assign bus.evt_code   = empty ? 8'h00 : code_mem[rd_ptr];
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf_q;

`ifdef KBD_ASCII_EN
  logic [7:0] ascii_map, ascii_in;
  logic [7:0] ascii_mem [DEPTH];

  kbd_ascii_map u_ascii_map (
    .code  (byte_q),
    .shift (shift_q),
    .ascii (ascii_map)
  );

  assign ascii_in = ext_pend ? 8'h00 : ascii_map;

  always_ff @(posedge fclk) begin
    if (wr_en) ascii_mem[wr_ptr] <= ascii_in;
  end

  assign bus.evt_ascii = empty ? 8'h00 : ascii_mem[rd_ptr];
`else
  assign bus.evt_ascii = 8'h00;
`endif

endmodule
